hq2x_sd_timing: RTL

- Timing front-end that sits directly upstream of the Hq2x scaler inside the scandoubler.
- Measures the incoming pixel period and line length in clk cycles, and produces the Hq2x pacing signals: ce_in (4 per input pixel), ce_out (2 per input pixel), reset_line, reset_frame and read_y.
- Produces the doubled-rate output sync/blank (hs_out, vs_out, hblank_out) and forwards a registered pixel aligned to the first ce_in of each pixel.

---
 rtl/hq2x_sd_timing.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/hq2x_sd_timing.sv
// Timing front-end for the Hq2x scaler: measures pixel period and line length,
// and derives the Hq2x pacing enables plus doubled-rate sync/blank outputs.
module hq2x_sd_timing #(
    parameter int CNT_W  = 12,
    parameter int PER_W  = 6,
    parameter int DWIDTH = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic [DWIDTH:0]   pix_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              hb_in,
    input  logic              vb_in,
    output logic [DWIDTH:0]   pix_out,
    output logic              ce_in,
    output logic              ce_out,
    output logic              reset_line,
    output logic              reset_frame,
    output logic [1:0]        read_y,
    output logic              hs_out,
    output logic              vs_out,
    output logic              hblank_out,
    output logic              period_err
);

    localparam logic [PER_W-1:0] PER_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ---------------- pixel period ----------------
    logic [PER_W-1:0] per_cnt, per_p, per_nxt;
    logic [PER_W-1:0] p_q1, p_h, p_q3;
    logic [PER_W+1:0] p_x3;
    logic             pix_seen, ce_pix_d, per_ok;

    assign per_nxt = (per_cnt == PER_MAX) ? PER_MAX : per_cnt + PER_W'(1);
    assign p_x3    = {2'b00, per_p} + {1'b0, per_p, 1'b0};
    assign p_q1    = per_p >> 2;
    assign p_h     = per_p >> 1;
    assign p_q3    = p_x3[PER_W+1:2];
    assign per_ok  = (per_p >= PER_W'(4));

    // The per_cnt==0 slot is the registered ce_pix, so the first ce_in of a
    // pixel lines up with pix_out and degenerate periods fall back to ce_pix.
    assign ce_in  = ce_pix_d | (per_ok & ((per_cnt == p_q1) | (per_cnt == p_h) | (per_cnt == p_q3)));
    assign ce_out = ce_pix_d | (per_ok & (per_cnt == p_h));

    always_ff @(posedge clk) begin
        if (reset) begin
            per_cnt    <= '0;
            per_p      <= '0;
            pix_seen   <= 1'b0;
            ce_pix_d   <= 1'b0;
            pix_out    <= '0;
            period_err <= 1'b0;
        end else begin
            ce_pix_d <= ce_pix;
            if (ce_pix) begin
                per_cnt  <= '0;
                pix_out  <= pix_in;
                pix_seen <= 1'b1;
                // first pulse after reset has no start reference
                if (pix_seen) begin
                    per_p <= per_nxt;
                    if (per_nxt < PER_W'(4))
                        period_err <= 1'b1;
                end
            end else if (per_cnt != PER_MAX) begin
                per_cnt <= per_cnt + PER_W'(1);
            end
        end
    end

    // ---------------- input / output line ----------------
    logic [CNT_W-1:0] pos_cnt, pos_nxt, line_len, hbs, hbe, hse;
    logic [CNT_W-1:0] opos, half_len, o_last;
    logic             hs_prev, hs_q, line_seen, line_ok, ry_half, ry_buf;
    logic             hs_rise, hs_fall, hb_rise, hb_fall, vb_fall, mid_wrap;

    assign pos_nxt  = (pos_cnt == CNT_MAX) ? CNT_MAX : pos_cnt + CNT_W'(1);
    assign half_len = line_len >> 1;
    assign o_last   = half_len - CNT_W'(1);
    assign hs_rise  = ce_pix & hs_in & ~hs_prev;
    assign hs_fall  = hs_q & ~hs_in;
    assign hb_rise  = hb_in & ~reset_line;
    assign hb_fall  = reset_line & ~hb_in;
    assign vb_fall  = reset_frame & ~vb_in;
    assign mid_wrap = line_ok & (opos == o_last) & ~ry_half;
    assign read_y   = {ry_buf, ry_half};

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_cnt     <= '0;
            line_len    <= '0;
            hbs         <= '0;
            hbe         <= '0;
            hse         <= '0;
            opos        <= '0;
            hs_prev     <= 1'b0;
            hs_q        <= 1'b0;
            line_seen   <= 1'b0;
            line_ok     <= 1'b0;
            ry_half     <= 1'b0;
            ry_buf      <= 1'b0;
            reset_line  <= 1'b0;
            reset_frame <= 1'b0;
            vs_out      <= 1'b0;
        end else begin
            hs_q        <= hs_in;
            reset_line  <= hb_in;
            reset_frame <= vb_in;
            if (ce_pix)
                hs_prev <= hs_in;

            if (hs_rise) begin
                pos_cnt   <= '0;
                line_seen <= 1'b1;
                if (line_seen) begin
                    line_len <= pos_nxt;
                    line_ok  <= 1'b1;
                end
            end else if (pos_cnt != CNT_MAX) begin
                pos_cnt <= pos_cnt + CNT_W'(1);
            end

            if (hb_rise) hbs <= pos_cnt;
            if (hb_fall) hbe <= pos_cnt;
            if (hs_fall) hse <= pos_cnt;

            // Two output lines per input line; a third wrap holds at o_last.
            if (hs_rise) begin
                opos    <= '0;
                ry_half <= 1'b0;
            end else if (mid_wrap) begin
                opos    <= '0;
                ry_half <= 1'b1;
            end else if (!(line_ok && opos == o_last) && opos != CNT_MAX) begin
                opos <= opos + CNT_W'(1);
            end

            if (hs_rise | mid_wrap)
                vs_out <= vs_in;

            if (vb_fall)
                ry_buf <= 1'b0;
            else if (hb_fall)
                ry_buf <= ~ry_buf;
        end
    end

    logic [CNT_W-1:0] hbs_h, hbe_h, hse_h;
    assign hbs_h = hbs >> 1;
    assign hbe_h = hbe >> 1;
    assign hse_h = hse >> 1;

    always_comb begin
        hs_out     = hs_q;
        hblank_out = reset_line;
        if (line_ok) begin
            hs_out = (opos < hse_h);
            if (hbs <= hbe)
                hblank_out = (opos >= hbs_h) && (opos < hbe_h);
            else
                hblank_out = (opos >= hbs_h) || (opos < hbe_h);
        end
    end

endmodule
